prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 23 ++
 rtl/byte_packer.sv | 44 ++++
 rtl/prog_loader.sv | 193 +++++++++++++++++++
 tb/tb_prog_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time program loader.
package loader_pkg;

  // Loader sequencing: header, payload words, checksum, verdict, terminal states.
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    CSUM  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Byte length of the word-count header and of the trailing checksum field.
  localparam int HDR_BYTES  = 4;
  localparam int CSUM_BYTES = 4;

  // Running image checksum: plain 32-bit addition that wraps modulo 2^32.
  function automatic logic [31:0] sum32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words. The completed word is
// presented combinationally together with its 4th byte so the caller can
// register it on the same edge that accepts that byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic [1:0]  o_idx
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // Byte index counter and storage for the three lower bytes of the word.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_valid) begin
      case (r_idx)
        2'd0:    r_shift[7:0]   <= i_data;
        2'd1:    r_shift[15:8]  <= i_data;
        2'd2:    r_shift[23:16] <= i_data;
        default: r_shift        <= r_shift;
      endcase
      r_idx <= r_idx + 2'd1;
    end else begin
      r_idx   <= r_idx;
      r_shift <= r_shift;
    end
  end

  // Word completes on the byte that lands in the top lane.
  always_comb begin
    o_word_valid = i_valid && (r_idx == 2'd3);
    o_word       = {i_data, r_shift};
    o_idx        = r_idx;
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length/payload/checksum byte frame,
// writes payload words into BRAM from BASE_WORD upward and releases the
// core only once the whole image is present and its checksum matches.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 1024,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] BASE_EXT     = (ADDR_W+1)'(BASE_WORD);
  localparam logic [31:0]     MAX_EXT      = 32'(MAX_WORDS);
  localparam logic [1:0]      HDR_LAST_IDX = 2'(HDR_BYTES - 1);
  localparam logic [1:0]      CSUM_LAST_IDX = 2'(CSUM_BYTES - 1);

  state_t            r_state;
  logic              r_s_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_hold;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_cnt;
  logic [31:0]       r_sum;
  logic [31:0]       r_csum;
  logic              r_last_seen;

  logic              w_xfer;
  logic              w_clr;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [1:0]        w_idx;
  logic              w_final_byte;
  logic              w_bad_last;
  logic              w_n_bad;
  logic [ADDR_W:0]   w_cnt_next;

  // Framing decode around the current byte handshake.
  always_comb begin
    w_xfer       = s_valid && r_s_ready;
    w_clr        = (r_state == CHECK) || (r_state == DONE) || (r_state == ERR);
    w_final_byte = (r_state == CSUM) && (w_idx == CSUM_LAST_IDX);
    w_bad_last   = w_xfer && s_last && !w_final_byte;
    w_n_bad      = (w_word == 32'd0) || (w_word > MAX_EXT);
    w_cnt_next   = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
  end

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_valid      (w_xfer),
    .i_data       (s_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_idx        (w_idx)
  );

  // Loader FSM with registered stream, BRAM and core-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HDR;
      r_s_ready   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR_W'(BASE_WORD);
      r_mem_wdata <= 32'd0;
      r_core_hold <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_sum       <= 32'd0;
      r_csum      <= 32'd0;
      r_last_seen <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        HDR: begin
          r_s_ready <= 1'b1;
          if (w_bad_last) begin
            r_state   <= ERR;
            r_err     <= 1'b1;
            r_s_ready <= 1'b0;
          end else if (w_xfer && (w_idx == HDR_LAST_IDX)) begin
            if (w_n_bad) begin
              r_state   <= ERR;
              r_err     <= 1'b1;
              r_s_ready <= 1'b0;
            end else begin
              r_n     <= w_word[ADDR_W:0];
              r_cnt   <= '0;
              r_sum   <= 32'd0;
              r_state <= DATA;
            end
          end else begin
            r_state <= HDR;
          end
        end
        DATA: begin
          if (w_bad_last) begin
            // Offending byte never reaches memory, even if it completes a word.
            r_state   <= ERR;
            r_err     <= 1'b1;
            r_s_ready <= 1'b0;
          end else if (w_word_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_word;
            r_mem_addr  <= ADDR_W'(BASE_EXT + r_cnt);
            r_sum       <= sum32(r_sum, w_word);
            r_cnt       <= w_cnt_next;
            if (w_cnt_next == r_n) begin
              r_state <= CSUM;
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_state <= DATA;
          end
        end
        CSUM: begin
          if (w_bad_last) begin
            r_state   <= ERR;
            r_err     <= 1'b1;
            r_s_ready <= 1'b0;
          end else if (w_xfer && (w_idx == CSUM_LAST_IDX)) begin
            r_csum      <= w_word;
            r_last_seen <= s_last;
            r_s_ready   <= 1'b0;
            r_state     <= CHECK;
          end else begin
            r_state <= CSUM;
          end
        end
        CHECK: begin
          r_s_ready <= 1'b0;
          if ((r_csum == r_sum) && r_last_seen) begin
            r_done      <= 1'b1;
            r_core_hold <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_err       <= 1'b1;
            r_core_hold <= 1'b1;
            r_state     <= ERR;
          end
        end
        DONE: begin
          r_s_ready <= 1'b0;
          r_state   <= DONE;
        end
        ERR: begin
          r_s_ready   <= 1'b0;
          r_err       <= 1'b1;
          r_core_hold <= 1'b1;
          r_state     <= ERR;
        end
        default: begin
          r_s_ready   <= 1'b0;
          r_err       <= 1'b1;
          r_core_hold <= 1'b1;
          r_state     <= ERR;
        end
      endcase
    end
  end

  // Drive the ports straight from their registers.
  always_comb begin
    s_ready   = r_s_ready;
    mem_we    = r_mem_we;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    core_hold = r_core_hold;
    done      = r_done;
    err       = r_err;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tmo    = 0;

  logic [31:0] mem_model [16];
  int          wr_count;
  int          dbl;
  logic        prev_we;
  logic [15:0] first_addr;

  logic [7:0] good [16] = '{8'h02, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h00, 8'h00, 8'h00,
                            8'hEF, 8'hBE, 8'hAD, 8'hDE,
                            8'h02, 8'hBF, 8'hAD, 8'hDE};

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  // BRAM model: captures writes, the first write address and back-to-back pulses.
  always @(negedge clk) begin
    if (rst) begin
      wr_count   = 0;
      dbl        = 0;
      prev_we    = 1'b0;
      first_addr = 16'hFFFF;
      for (int i = 0; i < 16; i++) mem_model[i] = 32'd0;
    end else begin
      if (mem_we) begin
        if (prev_we) dbl++;
        if (wr_count == 0) first_addr = mem_addr;
        mem_model[mem_addr[3:0]] = mem_wdata;
        wr_count++;
      end
      prev_we = mem_we;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int max_bub);
    int t;
    int nb;
    nb = (max_bub > 0) ? int'($urandom_range(max_bub, 0)) : 0;
    s_valid = 1'b0;
    repeat (nb) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    t = 0;
    while (!s_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      n_tmo++;
    end else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_image(input logic bad_csum, input int max_bub);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = good[i];
      if (bad_csum && i == 15) b = 8'hDF;
      send_byte(b, (i == 15), max_bub);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_good(input string tag);
    check_val({tag, "_mem0"}, mem_model[0], 32'h00000013);
    check_val({tag, "_mem1"}, mem_model[1], 32'hDEADBEEF);
    check_val({tag, "_wrcnt"}, 32'(wr_count), 32'd2);
    check_val({tag, "_dbl"}, 32'(dbl), 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    check_val({tag, "_hold"}, {31'd0, core_hold}, 32'd0);
    check_val({tag, "_err"}, {31'd0, err}, 32'd0);
    check_val({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and s_ready timing.
    hold_reset();
    check_val("rst_ready", {31'd0, s_ready}, 32'd0);
    check_val("rst_we", {31'd0, mem_we}, 32'd0);
    check_val("rst_addr", {16'd0, mem_addr}, 32'd0);
    check_val("rst_wdata", mem_wdata, 32'd0);
    check_val("rst_hold", {31'd0, core_hold}, 32'd1);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    release_reset();
    check_val("ready_after_rst", {31'd0, s_ready}, 32'd1);

    // Good image without bubbles, with write-pulse timing checks.
    for (int i = 0; i < 16; i++) begin
      send_byte(good[i], (i == 15), 0);
      if (i == 7) begin
        check_val("w0_we", {31'd0, mem_we}, 32'd1);
        check_val("w0_addr", {16'd0, mem_addr}, 32'd0);
        check_val("w0_data", mem_wdata, 32'h00000013);
      end
      if (i == 8) check_val("w0_we_off", {31'd0, mem_we}, 32'd0);
      if (i == 11) begin
        check_val("w1_addr", {16'd0, mem_addr}, 32'd1);
        check_val("w1_data", mem_wdata, 32'hDEADBEEF);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_good("good");

    // Same image with random valid bubbles.
    hold_reset();
    release_reset();
    send_image(1'b0, 3);
    check_good("bubble");

    // Wrong checksum: words land, load rejected.
    hold_reset();
    release_reset();
    send_image(1'b1, 0);
    check_val("csum_mem0", mem_model[0], 32'h00000013);
    check_val("csum_mem1", mem_model[1], 32'hDEADBEEF);
    check_val("csum_err", {31'd0, err}, 32'd1);
    check_val("csum_done", {31'd0, done}, 32'd0);
    check_val("csum_hold", {31'd0, core_hold}, 32'd1);
    check_val("csum_ready", {31'd0, s_ready}, 32'd0);

    // Header N=0.
    hold_reset();
    release_reset();
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    check_val("n0_err", {31'd0, err}, 32'd1);
    check_val("n0_ready", {31'd0, s_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("n0_wr", 32'(wr_count), 32'd0);

    // Header N=1025.
    hold_reset();
    release_reset();
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    check_val("n1025_err", {31'd0, err}, 32'd1);
    check_val("n1025_hold", {31'd0, core_hold}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("n1025_wr", 32'(wr_count), 32'd0);

    // Header N=1024 is the largest accepted image.
    hold_reset();
    release_reset();
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    check_val("n1024_err", {31'd0, err}, 32'd0);
    check_val("n1024_ready", {31'd0, s_ready}, 32'd1);

    // s_last on the 6th byte.
    hold_reset();
    release_reset();
    for (int i = 0; i < 6; i++) send_byte(good[i], (i == 5), 0);
    check_val("last6_err", {31'd0, err}, 32'd1);
    check_val("last6_hold", {31'd0, core_hold}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check_val("last6_wr", 32'(wr_count), 32'd0);
    check_val("last6_ready", {31'd0, s_ready}, 32'd0);

    // Abort after 1.5 words, then reload the full image.
    hold_reset();
    release_reset();
    for (int i = 0; i < 10; i++) send_byte(good[i], 1'b0, 0);
    check_val("abort_pre_wr", 32'(wr_count), 32'd1);
    hold_reset();
    release_reset();
    send_image(1'b0, 2);
    check_val("abort_first", {16'd0, first_addr}, 32'd0);
    check_good("reload");

    // Reset on the edge that would complete word 0 suppresses its write.
    hold_reset();
    release_reset();
    for (int i = 0; i < 7; i++) send_byte(good[i], 1'b0, 0);
    s_valid = 1'b1;
    s_data = good[7];
    rst = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check_val("inflight_we", {31'd0, mem_we}, 32'd0);
    check_val("inflight_addr", {16'd0, mem_addr}, 32'd0);
    release_reset();
    send_image(1'b0, 0);
    check_val("inflight_first", {16'd0, first_addr}, 32'd0);
    check_good("inflight");

    check_val("no_stall", 32'(n_tmo), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
